pc_gen: RTL and testbench

PC_GEN -- requirements
Module: pc_gen

---
 rtl/rv_pkg.sv | 15 +
 rtl/pc_incrementer.sv | 12 +
 rtl/pc_gen.sv | 82 ++++++++
 tb/tb_pc_gen.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared fetch-path definitions: PC width, instruction size and the
// program-counter generator state encoding.
package rv_pkg;

  localparam int unsigned PC_WIDTH    = 64;
  localparam int unsigned INSTR_BYTES = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    BUBBLE = 2'd2,
    TRAP   = 2'd3
  } pc_state_t;

endpackage

// File: rtl/pc_incrementer.sv
// Sequential-fetch adder: pc + INSTR_BYTES, modulo 2^PC_WIDTH.
// The carry-out is discarded, so the top of the address space wraps to 0.
module pc_incrementer
  import rv_pkg::*;
(
  input  logic [PC_WIDTH-1:0] pc,
  output logic [PC_WIDTH-1:0] pc_next
);

  assign pc_next = pc + PC_WIDTH'(INSTR_BYTES);

endmodule

// File: rtl/pc_gen.sv
// Program-counter generator for the fetch stage.
// IDLE after reset, RUN while fetching, BUBBLE for one invalid cycle after
// each redirect, TRAP on a misaligned redirect target.
// Optional feature: define PC_ALIGN_CHECK_EN to trap on misaligned branch
// targets; otherwise the low two target bits are forced to zero and TRAP
// is never entered.
module pc_gen
  import rv_pkg::*;
#(
  parameter logic [PC_WIDTH-1:0] RESET_PC = 64'h0000_0000_0000_0000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                if_ready,
  input  logic                branch_taken,
  input  logic [PC_WIDTH-1:0] branch_target,
  output logic [PC_WIDTH-1:0] pc_out,
  output logic                pc_valid,
  output logic [PC_WIDTH-1:0] pc_plus4,
  output logic [31:0]         redirect_count,
  output logic                misalign_err
);

  pc_state_t           state;
  logic                accept_redirect;
  logic                misaligned;
  logic [PC_WIDTH-1:0] redirect_pc;

  pc_incrementer u_inc (
    .pc      (pc_out),
    .pc_next (pc_plus4)
  );

  assign pc_valid        = (state == RUN);
  assign accept_redirect = branch_taken && ((state == RUN) || (state == BUBBLE));
  assign redirect_pc     = branch_target & ~PC_WIDTH'(INSTR_BYTES - 1);

`ifdef PC_ALIGN_CHECK_EN
  assign misaligned = (branch_target[1:0] != 2'b00);

  // Sticky misaligned-target flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign_err <= 1'b0;
    end else if (accept_redirect && misaligned) begin
      misalign_err <= 1'b1;
    end
  end
`else
  assign misaligned   = 1'b0;
  assign misalign_err = 1'b0;
`endif

  // Redirects take priority over the handshake in both RUN and BUBBLE;
  // a redirect during BUBBLE re-arms the same bubble rather than adding one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      pc_out         <= RESET_PC;
      redirect_count <= '0;
    end else if (accept_redirect) begin
      if (misaligned) begin
        state <= TRAP;
      end else begin
        state  <= BUBBLE;
        pc_out <= redirect_pc;
        if (redirect_count != '1) begin
          redirect_count <= redirect_count + 32'd1;
        end
      end
    end else begin
      case (state)
        IDLE:    state <= RUN;
        RUN:     if (pc_valid && if_ready) pc_out <= pc_plus4;
        BUBBLE:  state <= RUN;
        TRAP:    state <= TRAP;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
// Directed self-checking bench for pc_gen. A second instance with
// RESET_PC at the top of the address space exercises increment wrap.
module tb_pc_gen;
  import rv_pkg::*;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                if_ready = 1'b0;
  logic                branch_taken = 1'b0;
  logic [PC_WIDTH-1:0] branch_target = '0;

  logic [PC_WIDTH-1:0] pc_out, pc_plus4, w_pc_out, w_pc_plus4;
  logic                pc_valid, misalign_err, w_pc_valid, w_misalign_err;
  logic [31:0]         redirect_count, w_redirect_count;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  pc_gen dut (
    .clk(clk), .rst_n(rst_n), .if_ready(if_ready), .branch_taken(branch_taken),
    .branch_target(branch_target), .pc_out(pc_out), .pc_valid(pc_valid),
    .pc_plus4(pc_plus4), .redirect_count(redirect_count), .misalign_err(misalign_err)
  );

  pc_gen #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) dut_w (
    .clk(clk), .rst_n(rst_n), .if_ready(if_ready), .branch_taken(branch_taken),
    .branch_target(branch_target), .pc_out(w_pc_out), .pc_valid(w_pc_valid),
    .pc_plus4(w_pc_plus4), .redirect_count(w_redirect_count), .misalign_err(w_misalign_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; if_ready = 1'b0; branch_taken = 1'b0;
    #12;
    vectors++; if (pc_out !== 64'h0) begin miscompares++; $display("FAIL reset_pc got %h want %h", pc_out, 64'h0); end
    vectors++; if (pc_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b want 0", pc_valid); end
    vectors++; if (redirect_count !== 32'd0) begin miscompares++; $display("FAIL reset_count got %0d want 0", redirect_count); end
    vectors++; if (misalign_err !== 1'b0) begin miscompares++; $display("FAIL reset_err got %b want 0", misalign_err); end
    vectors++; if (w_pc_out !== 64'hFFFF_FFFF_FFFF_FFFC) begin miscompares++; $display("FAIL reset_pc_w got %h want fffffffffffffffc", w_pc_out); end
    step();
    rst_n = 1'b1; if_ready = 1'b1;
    // IDLE cycle is still invalid
    vectors++; if (pc_valid !== 1'b0) begin miscompares++; $display("FAIL idle_valid got %b want 0", pc_valid); end
    step();
    vectors++; if (pc_valid !== 1'b1) begin miscompares++; $display("FAIL run_valid got %b want 1", pc_valid); end
    vectors++; if (pc_out !== 64'h0) begin miscompares++; $display("FAIL first_pc got %h want 0", pc_out); end
    vectors++; if (pc_plus4 !== 64'h4) begin miscompares++; $display("FAIL first_plus4 got %h want 4", pc_plus4); end
    vectors++; if (w_pc_plus4 !== 64'h0) begin miscompares++; $display("FAIL wrap_plus4 got %h want 0", w_pc_plus4); end
  endtask

  task automatic test_increment();
    step();
    vectors++; if (pc_out !== 64'h4) begin miscompares++; $display("FAIL inc_pc4 got %h want 4", pc_out); end
    vectors++; if (w_pc_out !== 64'h0) begin miscompares++; $display("FAIL wrap_pc got %h want 0", w_pc_out); end
    vectors++; if (w_pc_valid !== 1'b1) begin miscompares++; $display("FAIL wrap_valid got %b want 1", w_pc_valid); end
    vectors++; if (w_misalign_err !== 1'b0) begin miscompares++; $display("FAIL wrap_err got %b want 0", w_misalign_err); end
    step();
    vectors++; if (pc_out !== 64'h8) begin miscompares++; $display("FAIL inc_pc8 got %h want 8", pc_out); end
  endtask

  task automatic test_stall();
    if_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++; if (pc_out !== 64'h8 || pc_valid !== 1'b1) begin
        miscompares++; $display("FAIL stall_hold[%0d] got pc=%h v=%b want pc=8 v=1", i, pc_out, pc_valid);
      end
    end
    if_ready = 1'b1;
    step();
    vectors++; if (pc_out !== 64'hC) begin miscompares++; $display("FAIL stall_resume got %h want c", pc_out); end
  endtask

  task automatic test_branch();
    branch_taken = 1'b1; branch_target = 64'h100;
    step();
    branch_taken = 1'b0;
    vectors++; if (pc_out !== 64'h100 || pc_valid !== 1'b0) begin miscompares++; $display("FAIL br_bubble got pc=%h v=%b want pc=100 v=0", pc_out, pc_valid); end
    vectors++; if (redirect_count !== 32'd1) begin miscompares++; $display("FAIL br_count got %0d want 1", redirect_count); end
    step();
    vectors++; if (pc_out !== 64'h100 || pc_valid !== 1'b1) begin miscompares++; $display("FAIL br_valid got pc=%h v=%b want pc=100 v=1", pc_out, pc_valid); end
    step();
    vectors++; if (pc_out !== 64'h104) begin miscompares++; $display("FAIL br_next got %h want 104", pc_out); end
  endtask

  task automatic test_back_to_back();
    branch_taken = 1'b1; branch_target = 64'h200;
    step();
    branch_target = 64'h300;
    vectors++; if (pc_out !== 64'h200 || pc_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_first got pc=%h v=%b want pc=200 v=0", pc_out, pc_valid); end
    step();
    branch_taken = 1'b0;
    vectors++; if (pc_out !== 64'h300 || pc_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_second got pc=%h v=%b want pc=300 v=0", pc_out, pc_valid); end
    step();
    vectors++; if (pc_out !== 64'h300 || pc_valid !== 1'b1) begin miscompares++; $display("FAIL b2b_valid got pc=%h v=%b want pc=300 v=1", pc_out, pc_valid); end
    vectors++; if (redirect_count !== 32'd3) begin miscompares++; $display("FAIL b2b_count got %0d want 3", redirect_count); end
  endtask

  task automatic test_misalign();
    if_ready = 1'b0;
    branch_taken = 1'b1; branch_target = 64'h102;
    step();
    branch_taken = 1'b0; if_ready = 1'b1;
`ifdef PC_ALIGN_CHECK_EN
    vectors++; if (misalign_err !== 1'b1 || pc_valid !== 1'b0) begin miscompares++; $display("FAIL trap_enter got err=%b v=%b want err=1 v=0", misalign_err, pc_valid); end
    vectors++; if (pc_out !== 64'h300) begin miscompares++; $display("FAIL trap_pc got %h want 300", pc_out); end
    branch_taken = 1'b1; branch_target = 64'h400;
    step(); step();
    branch_taken = 1'b0;
    vectors++; if (misalign_err !== 1'b1 || pc_valid !== 1'b0 || pc_out !== 64'h300) begin
      miscompares++; $display("FAIL trap_sticky got err=%b v=%b pc=%h want err=1 v=0 pc=300", misalign_err, pc_valid, pc_out);
    end
    vectors++; if (redirect_count !== 32'd3) begin miscompares++; $display("FAIL trap_count got %0d want 3", redirect_count); end
`else
    vectors++; if (pc_out !== 64'h100 || pc_valid !== 1'b0) begin miscompares++; $display("FAIL mask_bubble got pc=%h v=%b want pc=100 v=0", pc_out, pc_valid); end
    vectors++; if (misalign_err !== 1'b0) begin miscompares++; $display("FAIL mask_err got %b want 0", misalign_err); end
    step();
    vectors++; if (pc_out !== 64'h100 || pc_valid !== 1'b1) begin miscompares++; $display("FAIL mask_run got pc=%h v=%b want pc=100 v=1", pc_out, pc_valid); end
    vectors++; if (redirect_count !== 32'd4) begin miscompares++; $display("FAIL mask_count got %0d want 4", redirect_count); end
`endif
  endtask

  task automatic test_reset_mid_stall();
    if_ready = 1'b0;
    step(); step();
    #2 rst_n = 1'b0;
    #1;
    vectors++; if (pc_out !== 64'h0 || pc_valid !== 1'b0) begin miscompares++; $display("FAIL async_rst got pc=%h v=%b want pc=0 v=0", pc_out, pc_valid); end
    vectors++; if (redirect_count !== 32'd0 || misalign_err !== 1'b0) begin miscompares++; $display("FAIL async_rst_cnt got cnt=%0d err=%b want 0 0", redirect_count, misalign_err); end
    vectors++; if (w_pc_out !== 64'hFFFF_FFFF_FFFF_FFFC) begin miscompares++; $display("FAIL async_rst_w got %h want fffffffffffffffc", w_pc_out); end
    step();
    rst_n = 1'b1;
    // a redirect presented in IDLE must be ignored
    branch_taken = 1'b1; branch_target = 64'h500;
    step();
    branch_taken = 1'b0;
    vectors++; if (pc_out !== 64'h0 || pc_valid !== 1'b1) begin miscompares++; $display("FAIL idle_ignore got pc=%h v=%b want pc=0 v=1", pc_out, pc_valid); end
    vectors++; if (redirect_count !== 32'd0) begin miscompares++; $display("FAIL idle_ignore_cnt got %0d want 0", redirect_count); end
  endtask

  initial begin
    test_reset();
    test_increment();
    test_stall();
    test_branch();
    test_back_to_back();
    test_misalign();
    test_reset_mid_stall();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
